// File: rtl/sa_y_writeback_if.sv
// Bus bundle between the systolic array, sa_y_writeback and the SPAD_Y write port.
// Carries the SA result handshake (y_valid_i, y_in, base_addr_y, y_ready_o) and the
// SPAD_Y port (spad_gnt_i, spad_y_csb0, spad_y_web0, spad_y_addr0, spad_y_din0).
// slave: the writeback block; master: the environment driving it.
interface sa_y_writeback_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
);
  logic              y_valid_i;
  logic [N*DW-1:0]   y_in;
  logic [AW-1:0]     base_addr_y;
  logic              y_ready_o;
  logic              spad_gnt_i;
  logic              spad_y_csb0;
  logic              spad_y_web0;
  logic [AW-1:0]     spad_y_addr0;
  logic [DW-1:0]     spad_y_din0;

  modport slave (
    input  y_valid_i, y_in, base_addr_y, spad_gnt_i,
    output y_ready_o, spad_y_csb0, spad_y_web0, spad_y_addr0, spad_y_din0
  );

  modport master (
    output y_valid_i, y_in, base_addr_y, spad_gnt_i,
    input  y_ready_o, spad_y_csb0, spad_y_web0, spad_y_addr0, spad_y_din0
  );
endinterface

// File: rtl/sa_y_writeback.sv
// sa_y_writeback: buffers N-lane result vectors from the systolic array in a
// 2-entry FIFO and serialises each one into the SPAD_Y write port, lane 0 first,
// one word per granted cycle, pulsing done_o once a vector is fully written.
// Ports:
//   clk, n_rst   clock and asynchronous active-high reset
//   bus          SA handshake + SPAD_Y write port (sa_y_writeback_if.slave)
//   clr_ovf_i    clears the sticky overflow flag
//   busy_o       FIFO non-empty or a vector is in flight
//   done_o       one-cycle pulse per committed vector
//   ovf_o        sticky: a valid vector arrived while the FIFO was full
module sa_y_writeback #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic               clk,
  input  logic               n_rst,
  sa_y_writeback_if.slave    bus,
  input  logic               clr_ovf_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               ovf_o
);

  localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned VW    = N * DW;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [VW-1:0] data;
    logic [AW-1:0] base;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    FIN  = 2'd2
  } state_t;

  entry_t        mem_q [DEPTH];
  logic          head_q, tail_q;
  logic [1:0]    count_q, count_d;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          push, pop, drop;
  entry_t        head;

  logic          csb_c, web_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] din_c;

  // Ready depends only on occupancy; a same-edge pop never frees room for a push.
  assign bus.y_ready_o = (count_q < 2'(DEPTH));
  assign push          = bus.y_valid_i && bus.y_ready_o;
  assign drop          = bus.y_valid_i && !bus.y_ready_o;
  assign head          = mem_q[head_q];

  // Occupancy bookkeeping for the next edge.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Next-state and SPAD_Y strobes; strobes are driven only while writing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    csb_c   = 1'b1;
    web_c   = 1'b1;
    addr_c  = '0;
    din_c   = '0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (count_q != 2'd0) state_d = WR;
      end
      WR: begin
        csb_c  = 1'b0;
        web_c  = 1'b0;
        addr_c = head.base + AW'(idx_q);
        din_c  = head.data[32'(idx_q) * DW +: DW];
        if (bus.spad_gnt_i) begin
          if (idx_q == IW'(N - 1)) begin
            pop     = 1'b1;
            state_d = FIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.spad_y_csb0  = csb_c;
  assign bus.spad_y_web0  = web_c;
  assign bus.spad_y_addr0 = addr_c;
  assign bus.spad_y_din0  = din_c;

  // Control state, FIFO pointers and registered status outputs.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      ovf_o   <= 1'b0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      if (push) tail_q <= ~tail_q;
      if (pop)  head_q <= ~head_q;
      // Set has priority over clear.
      ovf_o   <= drop | (ovf_o & ~clr_ovf_i);
      done_o  <= (state_d == FIN);
      busy_o  <= (count_d != 2'd0) || (state_d != IDLE);
    end
  end

  // Payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{data: bus.y_in, base: bus.base_addr_y};
  end

endmodule

// File: tb/tb_sa_y_writeback.sv
// Scoreboard bench for sa_y_writeback: stimulus pushes expected SPAD_Y writes and
// done-pulse cycles into queues; a negedge monitor pops and compares them.
module tb_sa_y_writeback;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic n_rst;
  logic clr_ovf;
  logic busy, done, ovf;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  wr_t  wq[$];
  int   dq[$];

  sa_y_writeback_if #(.N(N), .AW(AW), .DW(DW)) bus_if ();

  sa_y_writeback #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus_if),
    .clr_ovf_i (clr_ovf),
    .busy_o    (busy),
    .done_o    (done),
    .ovf_o     (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every committed write and every done pulse must be expected.
  always @(negedge clk) begin
    if (!n_rst) begin
      if (!bus_if.spad_y_csb0 && !bus_if.spad_y_web0 && bus_if.spad_gnt_i) begin
        if (wq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected (cycle %0d)",
                   bus_if.spad_y_addr0, bus_if.spad_y_din0, cyc);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("write_addr", 64'(bus_if.spad_y_addr0), 64'(e.addr));
          chk("write_data", 64'(bus_if.spad_y_din0), 64'(e.data));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got pulse at cycle %0d, none expected", cyc);
        end else begin
          int exp_c;
          exp_c = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(exp_c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one vector for one edge; queue the first n_exp lane writes as expected.
  task automatic send(input logic [AW-1:0] base, input logic [DW-1:0] l0,
                      input logic [DW-1:0] l1, input logic [DW-1:0] l2,
                      input logic [DW-1:0] l3, input int n_exp);
    logic [DW-1:0] lanes [4];
    lanes = '{l0, l1, l2, l3};
    bus_if.y_valid_i   = 1'b1;
    bus_if.y_in        = {l3, l2, l1, l0};
    bus_if.base_addr_y = base;
    for (int i = 0; i < n_exp; i++)
      wq.push_back('{addr: AW'(base + AW'(i)), data: lanes[i]});
    tick();
    bus_if.y_valid_i = 1'b0;
  endtask

  task automatic drain(input string name, input int bound);
    int k;
    k = 0;
    while (!(wq.size() == 0 && dq.size() == 0 && !busy) && k < bound) begin
      tick();
      k++;
    end
    if (k >= bound) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got %0d writes/%0d dones pending, expected 0", name,
               wq.size(), dq.size());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(bus_if.y_ready_o), 64'd1);
    chk({tag, "_csb"},   64'(bus_if.spad_y_csb0), 64'd1);
    chk({tag, "_web"},   64'(bus_if.spad_y_web0), 64'd1);
    chk({tag, "_addr"},  64'(bus_if.spad_y_addr0), 64'd0);
    chk({tag, "_din"},   64'(bus_if.spad_y_din0), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_ovf"},   64'(ovf), 64'd0);
  endtask

  initial begin
    int c0;
    int r;
    n_rst              = 1'b1;
    clr_ovf            = 1'b0;
    bus_if.y_valid_i   = 1'b0;
    bus_if.y_in        = '0;
    bus_if.base_addr_y = '0;
    bus_if.spad_gnt_i  = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    n_rst = 1'b0;
    tick();

    // 1: single vector, grant held.
    bus_if.spad_gnt_i = 1'b1;
    c0 = cyc + 1;
    dq.push_back(c0 + 5);
    send(6'd8, 32'h428C0000, 32'h42A00000, 32'h42B40000, 32'h42C80000, 4);
    chk("t1_busy_after_push", 64'(busy), 64'd1);
    drain("t1", 20);
    chk("t1_busy_idle", 64'(busy), 64'd0);
    chk("t1_ovf", 64'(ovf), 64'd0);

    // 2: grant stall at idx=1 for 3 cycles.
    c0 = cyc + 1;
    dq.push_back(c0 + 8);
    send(6'd8, 32'h428C0000, 32'h42A00000, 32'h42B40000, 32'h42C80000, 4);
    tick(); tick();
    bus_if.spad_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_addr", 64'(bus_if.spad_y_addr0), 64'd9);
      chk("t2_stall_din",  64'(bus_if.spad_y_din0), 64'h42A00000);
      chk("t2_stall_csb",  64'(bus_if.spad_y_csb0), 64'd0);
      chk("t2_stall_web",  64'(bus_if.spad_y_web0), 64'd0);
      tick();
    end
    bus_if.spad_gnt_i = 1'b1;
    drain("t2", 20);

    // 3: overflow with grant withheld, then release.
    bus_if.spad_gnt_i = 1'b0;
    send(6'd16, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 4);
    send(6'd32, 32'h00000011, 32'h00000012, 32'h00000013, 32'h00000014, 4);
    bus_if.y_valid_i   = 1'b1;
    bus_if.y_in        = {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
    bus_if.base_addr_y = 6'd48;
    chk("t3_ready_full", 64'(bus_if.y_ready_o), 64'd0);
    tick();
    bus_if.y_valid_i = 1'b0;
    chk("t3_ovf_set", 64'(ovf), 64'd1);
    r = cyc;
    dq.push_back(r + 4);
    dq.push_back(r + 10);
    bus_if.spad_gnt_i = 1'b1;
    drain("t3", 30);
    chk("t3_ovf_sticky", 64'(ovf), 64'd1);
    chk("t3_ready_back", 64'(bus_if.y_ready_o), 64'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_cleared", 64'(ovf), 64'd0);

    // 4: address wrap 62,63,0,1.
    wq.push_back('{addr: 6'd62, data: 32'h3F800000});
    wq.push_back('{addr: 6'd63, data: 32'h40000000});
    wq.push_back('{addr: 6'd0,  data: 32'h40400000});
    wq.push_back('{addr: 6'd1,  data: 32'h40800000});
    c0 = cyc + 1;
    dq.push_back(c0 + 5);
    send(6'd62, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 0);
    drain("t4", 20);

    // 5: second vector pushed on the edge the first pops.
    c0 = cyc + 1;
    dq.push_back(c0 + 5);
    dq.push_back(c0 + 11);
    send(6'd20, 32'h41200000, 32'h41A00000, 32'h41F00000, 32'h42200000, 4);
    tick(); tick(); tick(); tick();
    chk("t5_ready_one_entry", 64'(bus_if.y_ready_o), 64'd1);
    send(6'd40, 32'hC1200000, 32'hC1A00000, 32'hC1F00000, 32'hC2200000, 4);
    drain("t5", 30);
    chk("t5_ovf", 64'(ovf), 64'd0);

    // 6: reset after lane 1 commits aborts the vector.
    c0 = cyc + 1;
    send(6'd4, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 2);
    tick(); tick(); tick();
    n_rst = 1'b1;
    #1;
    chk_reset_outputs("t6_in_reset");
    tick(); tick();
    n_rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_csb", 64'(bus_if.spad_y_csb0), 64'd1);
    chk("t6_pending_writes", 64'(wq.size()), 64'd0);
    chk("t6_pending_dones", 64'(dq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sa_y_writeback.md
Name: sa_y_writeback

Overview:
Downstream stage of the SPAD-fed systolic array. Captures each N-lane FP32 result vector the array produces and buffers it in a 2-entry vector FIFO. Serialises each vector into an OpenRAM-style output scratchpad (SPAD_Y) write port, one word per granted cycle, and pulses done when a vector is fully committed. This decouples SA compute from SPAD_Y port arbitration.

Parameters:
N, 4, number of lanes / result words per vector
AW, 6, SPAD_Y address width (depth 2^AW)
DW, 32, word width (FP32 bit pattern, word_t)

Ports:
clk  in  1  clock, all state on posedge
n_rst  in  1  reset, asynchronous, active-high (asserted when n_rst=1)
y_valid_i  in  1  result vector valid from SA
y_in  in  N*DW  packed results; lane i = y_in[i*DW +: DW]
base_addr_y  in  AW  SPAD_Y base address, sampled with y_in
y_ready_o  out  1  FIFO can accept a vector (entries < 2)
spad_gnt_i  in  1  SPAD_Y port grant; a write commits only when 1
spad_y_csb0  out  1  SPAD_Y chip select, active-low
spad_y_web0  out  1  SPAD_Y write enable, active-low
spad_y_addr0  out  AW  SPAD_Y write address
spad_y_din0  out  DW  SPAD_Y write data
clr_ovf_i  in  1  clears the sticky overflow flag
busy_o  out  1  entries > 0 or FSM not IDLE
done_o  out  1  one-cycle pulse per fully written vector
ovf_o  out  1  sticky: a valid vector was dropped

Behaviour:
- Reset values while n_rst=1 (asynchronous): FIFO empty, FSM=IDLE, idx=0, ovf_o=0, done_o=0, busy_o=0, y_ready_o=1, spad_y_csb0=1, spad_y_web0=1, spad_y_addr0=0, spad_y_din0=0.
- Reset mid-operation aborts the in-flight vector; strobes deassert immediately; buffered vectors are discarded; no partial-write recovery.
- Push: at a posedge with y_valid_i=1 and y_ready_o=1, store {y_in, base_addr_y} at tail.
- y_ready_o is combinational from the current entry count only. A same-edge pop does not make room for a push that edge.
- Drop: y_valid_i=1 with y_ready_o=0 discards the vector and sets ovf_o at that edge. ovf_o clears on clr_ovf_i; set wins if both occur on the same edge.
- Same-edge push and pop are both performed; entry count is unchanged.
- FSM states:
  - IDLE: go to WR when entries > 0; idx <= 0.
  - WR: spad_y_csb0=0, spad_y_web0=0, addr0 = (head.base + idx) mod 2^AW, din0 = head lane idx. All are combinational from state, idx and the head entry.
    - Posedge with spad_gnt_i=1: the word commits. If idx < N-1, idx <= idx+1. If idx = N-1, pop the head and go to FIN.
    - spad_gnt_i=0: hold idx; outputs stay stable.
  - FIN: done_o=1 for this cycle, then return to IDLE.
- Outside WR: csb0=1, web0=1, addr0=0, din0=0.
- Latency with gnt held 1: push at edge E0. Lane 0 is driven in cycle E1–E2 and commits at E2. Lane N-1 commits at E(N+1). done_o is high in cycle E(N+1)–E(N+2).
- Per-vector occupancy: N+2 cycles (IDLE and FIN overhead).
- Address arithmetic wraps modulo 2^AW; there is no carry-out or error.
- Write order is lane 0 first. Vectors are written in FIFO order.

Test Plan:
1. Single vector: base=8, y_in lanes = f2b(70.0, 80.0, 90.0, 100.0), gnt=1 -> writes to addr 8,9,10,11 on 4 consecutive edges with matching data; done_o for 1 cycle at E5; busy_o falls after FIN; ovf_o=0.
2. Grant stall: the same vector with gnt=0 for 3 cycles while idx=1 -> addr0=9 and din0=f2b(80.0) held stable, csb0/web0 stay low, no commit; resumes on gnt=1; done_o delayed exactly 3 cycles.
3. Overflow: 3 vectors pushed on consecutive edges with gnt=0 -> first two accepted, y_ready_o=0 at the third, ovf_o=1. Release gnt -> exactly 8 writes in order, then 2 done pulses. clr_ovf_i -> ovf_o=0.
4. Address wrap: base=62, N=4 -> addresses 62,63,0,1.
5. Push/pop same edge: second vector pushed on the edge the first pops (entries=1, 1->1) -> both vectors written; ovf_o=0.
6. Reset mid-write: assert n_rst after lane 1 commits -> strobes deassert immediately, all outputs at reset values. After deassert with no new valid -> no writes, busy_o=0.
